// File: rtl/bcd_countdown_timer_pkg.sv
// ============================================================================
//  Module : countdown_pkg
//  Brief  : State encoding, BCD limits and load sanitising for the MM:SS countdown timer.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package countdown_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_e;

   localparam logic [3:0] BCD_MAX_ONES     = 4'd9;
   localparam logic [3:0] BCD_MAX_TENS_SEC = 4'd5;

   // Clamp each digit to its legal range, so the largest loadable time is 99:59
   function automatic logic [15:0] bcd_sanitise(input logic [15:0] v);
      logic [3:0] mt, mo, st, so;
      mt = (v[15:12] > BCD_MAX_ONES)     ? BCD_MAX_ONES     : v[15:12];
      mo = (v[11:8]  > BCD_MAX_ONES)     ? BCD_MAX_ONES     : v[11:8];
      st = (v[7:4]   > BCD_MAX_TENS_SEC) ? BCD_MAX_TENS_SEC : v[7:4];
      so = (v[3:0]   > BCD_MAX_ONES)     ? BCD_MAX_ONES     : v[3:0];
      return {mt, mo, st, so};
   endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_countdown_timer_if.sv
// ============================================================================
//  Module : bcd_countdown_timer_if
//  Brief  : Control and status bundle of the countdown timer (master = controller).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface bcd_countdown_timer_if;
   logic        clear;
   logic        load;
   logic [15:0] load_value;
   logic        start;
   logic        pause;
   logic [15:0] value;
   logic        running;
   logic        expired;
   logic        done;

   modport master (
      output clear, load, load_value, start, pause,
      input  value, running, expired, done
   );

   modport slave (
      input  clear, load, load_value, start, pause,
      output value, running, expired, done
   );
endinterface

`default_nettype wire

// File: rtl/bcd_countdown_timer_dec.sv
// ============================================================================
//  Module : bcd_digit_dec
//  Brief  : One BCD digit of the decrement chain; wraps to max_val on borrow.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_digit_dec (
   input  wire logic [3:0] digit,
   input  wire logic       borrow_in,
   input  wire logic [3:0] max_val,
   output logic      [3:0] digit_next,
   output logic            borrow_out
);

   logic [4:0] w_sum;

   // Adding 1110 + 1 is d-1 in four bits; no carry-out means the digit was 0
   always_comb begin
      w_sum      = {1'b0, digit} + 5'b01110 + 5'd1;
      borrow_out = borrow_in & ~w_sum[4];
      if (!borrow_in)
         digit_next = digit;
      else if (!w_sum[4])
         digit_next = max_val;
      else
         digit_next = w_sum[3:0];
   end

endmodule

`default_nettype wire

// File: rtl/bcd_countdown_timer.sv
// ============================================================================
//  Module : bcd_countdown_timer
//  Brief  : MM:SS BCD countdown with prescaler and IDLE/RUN/PAUSED/DONE FSM.
//           Optional AUTO_RELOAD_EN: restart from the last loaded time on expiry.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_countdown_timer
   import countdown_pkg::*;
#(
   parameter int TICK_DIV = 50_000_000,
   parameter int CNT_W    = 26
) (
   input wire logic              clk,
   input wire logic              rst_n,
   bcd_countdown_timer_if.slave  bus
);

   localparam logic [1:0]       ST_IDLE   = IDLE;
   localparam logic [1:0]       ST_RUN    = RUN;
   localparam logic [1:0]       ST_PAUSED = PAUSED;
   localparam logic [1:0]       ST_DONE   = DONE;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

   logic [1:0]       r_state,   w_state_nxt;
   logic [15:0]      r_value,   w_value_nxt;
   logic [CNT_W-1:0] r_presc,   w_presc_nxt;
   logic             r_expired, w_expired_nxt;
   logic             r_running;
   logic             r_done;
   logic [15:0]      w_load_val;
   logic             w_tick;
   logic [15:0]      w_dec;
   logic [4:0]       w_borrow;
`ifdef AUTO_RELOAD_EN
   logic [15:0]      r_shadow,  w_shadow_nxt;
`endif

   assign w_load_val  = bcd_sanitise(bus.load_value);
   assign w_tick      = (r_state == ST_RUN) && (r_presc == TICK_LAST);
   assign w_borrow[0] = w_tick;

   // Digit order: 0 = sec_ones, 1 = sec_tens, 2 = min_ones, 3 = min_tens
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         bcd_digit_dec u_dec (
            .digit      (r_value[4*gi +: 4]),
            .borrow_in  (w_borrow[gi]),
            .max_val    ((gi == 1) ? BCD_MAX_TENS_SEC : BCD_MAX_ONES),
            .digit_next (w_dec[4*gi +: 4]),
            .borrow_out (w_borrow[gi+1])
         );
      end
   endgenerate

   always_comb begin
      w_state_nxt   = r_state;
      w_value_nxt   = r_value;
      w_presc_nxt   = r_presc;
      w_expired_nxt = 1'b0;
`ifdef AUTO_RELOAD_EN
      w_shadow_nxt  = r_shadow;
`endif
      if (bus.clear) begin
         w_state_nxt = ST_IDLE;
         w_value_nxt = 16'h0000;
         w_presc_nxt = '0;
`ifdef AUTO_RELOAD_EN
         w_shadow_nxt = 16'h0000;
`endif
      end else begin
         if (bus.load) begin
            w_value_nxt = w_load_val;
            w_presc_nxt = '0;
`ifdef AUTO_RELOAD_EN
            w_shadow_nxt = w_load_val;
`endif
         end
         case (r_state)
            ST_IDLE: begin
               if (bus.start && !bus.pause) begin
                  if (w_value_nxt != 16'h0000) begin
                     w_state_nxt = ST_RUN;
                  end else begin
                     w_state_nxt   = ST_DONE;
                     w_expired_nxt = 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (bus.pause) begin
                  w_state_nxt = ST_PAUSED;
               end else if (!bus.load) begin
                  w_presc_nxt = w_tick ? '0 : r_presc + CNT_W'(1);
                  // A top-digit borrow means the value was already 0000
                  if (w_tick && (w_dec == 16'h0000 || w_borrow[4])) begin
                     w_expired_nxt = 1'b1;
                     w_value_nxt   = 16'h0000;
`ifdef AUTO_RELOAD_EN
                     if (r_shadow != 16'h0000)
                        w_value_nxt = r_shadow;
                     else
                        w_state_nxt = ST_DONE;
`else
                     w_state_nxt = ST_DONE;
`endif
                  end else if (w_tick) begin
                     w_value_nxt = w_dec;
                  end
               end
            end
            ST_PAUSED: begin
               if (bus.start && !bus.pause)
                  w_state_nxt = ST_RUN;
            end
            ST_DONE: begin
               if (bus.load)
                  w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_value   <= 16'h0000;
         r_presc   <= '0;
         r_expired <= 1'b0;
         r_running <= 1'b0;
         r_done    <= 1'b0;
`ifdef AUTO_RELOAD_EN
         r_shadow  <= 16'h0000;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_value   <= w_value_nxt;
         r_presc   <= w_presc_nxt;
         r_expired <= w_expired_nxt;
         r_running <= (w_state_nxt == ST_RUN);
         r_done    <= (w_state_nxt == ST_DONE);
`ifdef AUTO_RELOAD_EN
         r_shadow  <= w_shadow_nxt;
`endif
      end
   end

   assign bus.value   = r_value;
   assign bus.running = r_running;
   assign bus.expired = r_expired;
   assign bus.done    = r_done;

endmodule

`default_nettype wire
